// File: rtl/gf_clmul_seq_pkg.sv
// Shared definitions for the GF(2) polynomial blocks: FSM state encoding and
// the CALC cycle count derived from operand width and bits-per-cycle.
package gf_clmul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_ncyc(input int data_width, input int bpc);
        return (data_width + bpc - 1) / bpc;
    endfunction

endpackage

// File: rtl/gf_clmul_seq_if.sv
// Operand/product handshake bundle of the carry-less multiplier.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are
// both high; the source holds valid and its data stable until that edge.
interface gf_clmul_seq_if #(
    parameter int DATA_WIDTH = 10
);
    localparam int GW = $clog2(DATA_WIDTH) + 1;

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [GW-1:0]           polyn_grade;
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*DATA_WIDTH-1:0] product;
    logic                    busy;

    modport master (
        output flush, in_valid, polyn_grade, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  flush, in_valid, polyn_grade, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/gf_clmul_seq_digit.sv
// Combinational partial product for one BPC-bit digit of b: the XOR of
// a shifted by (base + j) for every set bit j of the digit.
module gf_clmul_seq_digit #(
    parameter int DATA_WIDTH = 10,
    parameter int BPC        = 2,
    parameter int SW         = 4
) (
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [BPC-1:0]          i_b_digit,
    input  logic [SW-1:0]           i_base,
    output logic [2*DATA_WIDTH-1:0] o_term
);
    logic [2*DATA_WIDTH-1:0] w_a_ext;

    assign w_a_ext = (2*DATA_WIDTH)'(i_a);

    always_comb begin
        o_term = '0;
        for (int j = 0; j < BPC; j++) begin
            if (i_b_digit[j]) begin
                o_term = o_term ^ (w_a_ext << (int'(i_base) + j));
            end
        end
    end
endmodule

// File: rtl/gf_clmul_seq.sv
// Sequential carry-less multiplier: consumes BPC bits of b per CALC cycle and
// presents the unreduced 2*DATA_WIDTH product behind a valid/ready handshake.
module gf_clmul_seq
    import gf_clmul_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int BPC        = 2
) (
    input  logic                clk,
    input  logic                rst_l,
    gf_clmul_seq_if.slave       bus,
    output state_t              o_dbg_state
);
    localparam int NCYC = calc_ncyc(DATA_WIDTH, BPC);
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int BW   = NCYC * BPC;
    localparam int SW   = $clog2(BW + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [PW-1:0]         r_acc;
    logic [PW-1:0]         r_product;
    logic                  r_out_valid;

    logic                  w_in_ready;
    logic                  w_load;
    logic                  w_step;
    logic                  w_finish;
    logic                  w_release;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [BW-1:0]         w_b_ext;
    logic [BPC-1:0]        w_b_digit;
    logic [SW-1:0]         w_base;
    logic [PW-1:0]         w_term;
    logic [PW-1:0]         w_acc_nxt;

    // Grades 0 and 1 mean no usable field, so the whole operand is cleared.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_mask[i] = (int'(bus.polyn_grade) >= 2) && (i < int'(bus.polyn_grade));
        end
    end

    // b is zero-extended to whole digits so the last digit reads 0 past the top bit.
    assign w_b_ext   = BW'(r_b);
    assign w_b_digit = w_b_ext[int'(r_cnt)*BPC +: BPC];
    assign w_base    = SW'(int'(r_cnt) * BPC);
    assign w_acc_nxt = r_acc ^ w_term;

    gf_clmul_seq_digit #(
        .DATA_WIDTH (DATA_WIDTH),
        .BPC        (BPC),
        .SW         (SW)
    ) u_digit (
        .i_a       (r_a),
        .i_b_digit (w_b_digit),
        .i_base    (w_base),
        .o_term    (w_term)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == CW'(NCYC - 1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    w_release = 1'b1;
                    if (bus.in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = CALC;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Flush overrides everything, including an offered operand pair.
        if (bus.flush) begin
            w_state_nxt = IDLE;
            w_in_ready  = 1'b0;
            w_load      = 1'b0;
            w_step      = 1'b0;
            w_finish    = 1'b0;
            w_release   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_cnt       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_a   <= bus.a & w_mask;
                r_b   <= bus.b & w_mask;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_step) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_finish ? '0 : r_cnt + 1'b1;
                if (w_finish) r_product <= w_acc_nxt;
            end
            if (w_finish)       r_out_valid <= 1'b1;
            else if (w_release) r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;
    assign bus.busy      = (r_state != IDLE);
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_gf_clmul_seq.sv
// Bench for gf_clmul_seq: scenario tasks against a bit-pair polynomial product model.
module tb_gf_clmul_seq;
    import gf_clmul_seq_pkg::*;

    localparam int DW = 10;
    localparam int PW = 2 * DW;

    logic   clk;
    logic   rst_l;
    state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] exp_q[$];

    gf_clmul_seq_if #(.DATA_WIDTH(DW)) bus_if ();

    gf_clmul_seq #(.DATA_WIDTH(DW), .BPC(2)) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial product from the definition: coefficient i+j flips for every a_i*b_j pair.
    function automatic logic [PW-1:0] ref_clmul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input int grade);
        logic [PW-1:0] p;
        p = '0;
        if (grade >= 2) begin
            for (int i = 0; i < DW; i++)
                for (int j = 0; j < DW; j++)
                    if (i < grade && j < grade && a[i] && b[j]) p[i+j] = ~p[i+j];
        end
        return p;
    endfunction

    task automatic drive_idle();
        bus_if.flush       = 1'b0;
        bus_if.in_valid    = 1'b0;
        bus_if.polyn_grade = 5'd10;
        bus_if.a           = '0;
        bus_if.b           = '0;
        bus_if.out_ready   = 1'b1;
    endtask

    // Presents one operand pair for a single edge, then scrambles the operand pins.
    task automatic do_accept(input logic [DW-1:0] a, input logic [DW-1:0] b, input int grade);
        bus_if.a           = a;
        bus_if.b           = b;
        bus_if.polyn_grade = 5'(grade);
        bus_if.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.a        = DW'($urandom);
        bus_if.b        = DW'($urandom);
    endtask

    task automatic wait_result(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            lat++;
            if (bus_if.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid); end
        n_checks++;
        if (bus_if.product !== '0) begin n_fail++; $display("FAIL reset_product: got %h expected 0", bus_if.product); end
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        n_checks++;
        if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready); end
        rst_l = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int  lat;
        bit  ok;
        int  busy_low;
        do_accept(10'h003, 10'h003, 10);
        lat = 0; ok = 1'b0; busy_low = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus_if.busy !== 1'b1) busy_low++;
            @(posedge clk); #1;
            lat++;
            if (bus_if.out_valid) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || lat != 5) begin n_fail++; $display("FAIL basic_latency: got %0d (seen %0b) expected 5", lat, ok); end
        n_checks++;
        if (busy_low != 0) begin n_fail++; $display("FAIL basic_busy: got %0d low cycles expected 0", busy_low); end
        n_checks++;
        if (bus_if.product !== 20'h00005) begin n_fail++; $display("FAIL basic_product: got %h expected 00005", bus_if.product); end
        @(posedge clk); #1;
    endtask

    task automatic test_grades();
        int            lat;
        bit            ok;
        int            grades[3] = '{10, 4, 1};
        logic [PW-1:0] fixed[3]  = '{20'h55555, 20'h00055, 20'h00000};
        for (int g = 0; g < 3; g++) begin
            do_accept(10'h3FF, 10'h3FF, grades[g]);
            wait_result(lat, ok);
            n_checks++;
            if (!ok || bus_if.product !== fixed[g] || bus_if.product !== ref_clmul(10'h3FF, 10'h3FF, grades[g])) begin
                n_fail++;
                $display("FAIL grade_%0d_product: got %h (seen %0b) expected %h", grades[g], bus_if.product, ok, fixed[g]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int            lat;
        bit            ok;
        logic [PW-1:0] held;
        logic [DW-1:0] na, nb;
        bus_if.out_ready = 1'b0;
        do_accept(10'h2A5, 10'h13C, 10);
        wait_result(lat, ok);
        held = bus_if.product;
        n_checks++;
        if (!ok || held !== ref_clmul(10'h2A5, 10'h13C, 10)) begin
            n_fail++; $display("FAIL bp_first_product: got %h expected %h", held, ref_clmul(10'h2A5, 10'h13C, 10));
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.product !== held || bus_if.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got valid=%b product=%h in_ready=%b expected 1 %h 0",
                         bus_if.out_valid, bus_if.product, bus_if.in_ready, held);
            end
        end
        na = DW'($urandom); nb = DW'($urandom);
        bus_if.out_ready = 1'b1;
        bus_if.a = na; bus_if.b = nb; bus_if.polyn_grade = 5'd10; bus_if.in_valid = 1'b1;
        #1;
        n_checks++;
        if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus_if.in_ready); end
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        n_checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
            n_fail++; $display("FAIL bp_accept: got valid=%b busy=%b expected 0 1", bus_if.out_valid, bus_if.busy);
        end
        wait_result(lat, ok);
        n_checks++;
        if (!ok || lat != 5 || bus_if.product !== ref_clmul(na, nb, 10)) begin
            n_fail++; $display("FAIL bp_second: got lat=%0d product=%h expected 5 %h", lat, bus_if.product, ref_clmul(na, nb, 10));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int            n_sent = 0;
        int            n_recv = 0;
        int            acc_cyc[8];
        logic          take;
        logic [DW-1:0] ca, cb;
        int            cg;
        logic [PW-1:0] exp_p;
        ca = DW'($urandom); cb = DW'($urandom); cg = $urandom_range(0, 11);
        bus_if.a = ca; bus_if.b = cb; bus_if.polyn_grade = 5'(cg); bus_if.in_valid = 1'b1;
        bus_if.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && n_recv < 8; cyc++) begin
            take = bus_if.in_valid && bus_if.in_ready;
            if (bus_if.out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected: got %h expected none", bus_if.product);
                end else begin
                    exp_p = exp_q.pop_front();
                    if (bus_if.product !== exp_p) begin
                        n_fail++; $display("FAIL b2b_product_%0d: got %h expected %h", n_recv, bus_if.product, exp_p);
                    end
                end
                n_recv++;
            end
            @(posedge clk); #1;
            if (take) begin
                exp_q.push_back(ref_clmul(ca, cb, cg));
                acc_cyc[n_sent] = cyc;
                n_sent++;
                if (n_sent < 8) begin
                    ca = DW'($urandom); cb = DW'($urandom); cg = $urandom_range(0, 11);
                    bus_if.a = ca; bus_if.b = cb; bus_if.polyn_grade = 5'(cg);
                end else begin
                    bus_if.in_valid = 1'b0;
                end
            end
        end
        bus_if.in_valid = 1'b0;
        n_checks++;
        if (n_recv != 8 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d results expected 8", n_recv);
        end
        for (int k = 1; k < n_sent; k++) begin
            n_checks++;
            if (acc_cyc[k] - acc_cyc[k-1] != 6) begin
                n_fail++; $display("FAIL b2b_interval_%0d: got %0d expected 6", k, acc_cyc[k] - acc_cyc[k-1]);
            end
        end
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int rises;
        do_accept(10'h155, 10'h0F3, 10);
        @(posedge clk); #1;
        bus_if.flush = 1'b1;
        @(posedge clk); #1;
        bus_if.flush = 1'b0;
        n_checks++;
        if (dbg_state !== IDLE || bus_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_calc_state: got %0d busy=%b expected IDLE 0", dbg_state, bus_if.busy);
        end
        rises = 0;
        repeat (8) begin @(posedge clk); #1; if (bus_if.out_valid) rises++; end
        n_checks++;
        if (rises != 0 || bus_if.product !== '0) begin
            n_fail++; $display("FAIL flush_no_result: got %0d valid cycles product=%h expected 0 0", rises, bus_if.product);
        end
        bus_if.flush = 1'b1;
        bus_if.a = 10'h0FF; bus_if.b = 10'h0FF; bus_if.in_valid = 1'b1;
        #1;
        n_checks++;
        if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", bus_if.in_ready); end
        @(posedge clk); #1;
        bus_if.flush = 1'b0; bus_if.in_valid = 1'b0;
        rises = 0;
        repeat (8) begin
            if (bus_if.busy || bus_if.out_valid) rises++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (rises != 0) begin n_fail++; $display("FAIL flush_accept_blocked: got %0d active cycles expected 0", rises); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        do_accept(10'h003, 10'h003, 10);
        wait_result(lat, ok);
        @(posedge clk); #1;
        do_accept(10'h1C7, 10'h3A1, 10);
        @(posedge clk); #2;
        rst_l = 1'b0;
        #1;
        n_checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.product !== '0 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: got valid=%b product=%h busy=%b expected 0 0 0",
                     bus_if.out_valid, bus_if.product, bus_if.busy);
        end
        @(posedge clk); #1;
        rst_l = 1'b1;
        @(posedge clk); #1;
        do_accept(10'h200, 10'h200, 10);
        wait_result(lat, ok);
        n_checks++;
        if (!ok || bus_if.product !== 20'h40000) begin
            n_fail++; $display("FAIL post_reset_product: got %h expected 40000", bus_if.product);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_grades();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
